// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: execute-stage iterative multiply/divide unit with private HI/LO.
// MULT/MULTU use shift-add and DIV/DIVU use restoring division, one bit per clock.
// The unit also services MTHI/MTLO writes.
// Ports:
//   clk, rst (async, active-low)
//   start_in, op_in (00 MULT, 01 MULTU, 10 DIV, 11 DIVU), Reg1_in (rs), Reg2_in (rt)
//   hi_we_in, lo_we_in, wdata_in : MTHI/MTLO
//   hilo_read_in : MFHI/MFLO pending in ID/EX
//   flush_in     : abort in-flight op
//   busy_out, stall_out, done_out, HI_out, LO_out
//
// state | meaning
// IDLE  | no op in flight; MTHI/MTLO accepted, start accepted
// RUN   | one multiply/divide iteration per clock, WIDTH iterations
// FIX   | sign correction and HI/LO write-back
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_in,
  input  logic [1:0]       op_in,
  input  logic [WIDTH-1:0] Reg1_in,
  input  logic [WIDTH-1:0] Reg2_in,
  input  logic             hi_we_in,
  input  logic             lo_we_in,
  input  logic [WIDTH-1:0] wdata_in,
  input  logic             hilo_read_in,
  input  logic             flush_in,
  output logic             busy_out,
  output logic             stall_out,
  output logic             done_out,
  output logic [WIDTH-1:0] HI_out,
  output logic [WIDTH-1:0] LO_out
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

  state_t               r_state, w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_b;
  logic                 r_is_div;
  logic                 r_neg_res;
  logic                 r_neg_rem;
  logic                 r_done;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;

  logic                 w_signed;
  logic [WIDTH-1:0]     w_abs1;
  logic [WIDTH-1:0]     w_abs2;
  logic                 w_last;
  logic [WIDTH:0]       w_mul_sum;
  logic [WIDTH:0]       w_div_rem;
  logic                 w_div_ge;
  logic [WIDTH-1:0]     w_div_sub;
  logic [2*WIDTH-1:0]   w_prod_neg;
  logic [WIDTH-1:0]     w_quo_neg;
  logic [WIDTH-1:0]     w_rem_neg;

  assign w_signed = ~op_in[0];
  assign w_abs1   = (w_signed && Reg1_in[WIDTH-1]) ? -Reg1_in : Reg1_in;
  assign w_abs2   = (w_signed && Reg2_in[WIDTH-1]) ? -Reg2_in : Reg2_in;
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  // Multiply: multiplier sits in the low half of the accumulator and is shifted out
  // LSB-first while the partial product grows into the high half. r_b holds the
  // multiplicand for MUL and the divisor for DIV.
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);

  // Divide: shift the next dividend bit into the remainder. When the remainder is
  // >= divisor, the difference always fits WIDTH bits, so a WIDTH-bit subtract suffices.
  assign w_div_rem = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_div_ge  = (w_div_rem >= {1'b0, r_b});
  assign w_div_sub = w_div_rem[WIDTH-1:0] - r_b;

  assign w_prod_neg = -r_acc;
  assign w_quo_neg  = -r_acc[WIDTH-1:0];
  assign w_rem_neg  = -r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start_in && !flush_in) w_state_nxt = RUN;
      RUN:     if (flush_in) w_state_nxt = IDLE;
               else if (w_last) w_state_nxt = FIX;
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_b       <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_done    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_done <= (r_state == FIX) && !flush_in;
      unique case (r_state)
        IDLE: begin
          if (hi_we_in) r_hi <= wdata_in;
          if (lo_we_in) r_lo <= wdata_in;
          if (start_in && !flush_in) begin
            r_cnt     <= '0;
            r_is_div  <= op_in[1];
            r_neg_res <= w_signed && (Reg1_in[WIDTH-1] ^ Reg2_in[WIDTH-1]);
            r_neg_rem <= w_signed && Reg1_in[WIDTH-1];
            if (op_in[1]) begin
              r_acc <= {{WIDTH{1'b0}}, w_abs1};
              r_b   <= w_abs2;
            end else begin
              r_acc <= {{WIDTH{1'b0}}, w_abs2};
              r_b   <= w_abs1;
            end
          end
        end
        RUN: begin
          if (!flush_in) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_is_div)
              r_acc <= {(w_div_ge ? w_div_sub : w_div_rem[WIDTH-1:0]),
                        r_acc[WIDTH-2:0], w_div_ge};
            else
              r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
          end
        end
        FIX: begin
          // Divide by zero still runs the full latency and pulses done, but leaves HI/LO alone.
          if (!flush_in && !(r_is_div && (r_b == '0))) begin
            if (r_is_div) begin
              r_lo <= r_neg_res ? w_quo_neg : r_acc[WIDTH-1:0];
              r_hi <= r_neg_rem ? w_rem_neg : r_acc[2*WIDTH-1:WIDTH];
            end else begin
              r_lo <= r_neg_res ? w_prod_neg[WIDTH-1:0]       : r_acc[WIDTH-1:0];
              r_hi <= r_neg_res ? w_prod_neg[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_out  = (r_state != IDLE);
  assign stall_out = busy_out && (start_in || hilo_read_in || hi_we_in || lo_we_in);
  assign done_out  = r_done;
  assign HI_out    = r_hi;
  assign LO_out    = r_lo;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_in = 1'b0;
  logic [1:0]  op_in = 2'b00;
  logic [31:0] Reg1_in = '0;
  logic [31:0] Reg2_in = '0;
  logic        hi_we_in = 1'b0;
  logic        lo_we_in = 1'b0;
  logic [31:0] wdata_in = '0;
  logic        hilo_read_in = 1'b0;
  logic        flush_in = 1'b0;
  logic        busy_out, stall_out, done_out;
  logic [31:0] HI_out, LO_out;

  int n_pass = 0;
  int n_total = 0;

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_in(start_in), .op_in(op_in),
    .Reg1_in(Reg1_in), .Reg2_in(Reg2_in), .hi_we_in(hi_we_in), .lo_we_in(lo_we_in),
    .wdata_in(wdata_in), .hilo_read_in(hilo_read_in), .flush_in(flush_in),
    .busy_out(busy_out), .stall_out(stall_out), .done_out(done_out),
    .HI_out(HI_out), .LO_out(LO_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Issue an op, confirm 33 busy cycles, then the done pulse and the HI/LO result.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    start_in = 1'b1; op_in = op; Reg1_in = a; Reg2_in = b;
    tick();
    start_in = 1'b0;
    check({tag, " busy_after_start"}, {31'b0, busy_out}, 32'd1);
    repeat (32) tick();
    check({tag, " busy_cycle33"}, {31'b0, busy_out}, 32'd1);
    check({tag, " done_early"}, {31'b0, done_out}, 32'd0);
    tick();
    check({tag, " busy_end"}, {31'b0, busy_out}, 32'd0);
    check({tag, " done"}, {31'b0, done_out}, 32'd1);
    check({tag, " HI"}, HI_out, ehi);
    check({tag, " LO"}, LO_out, elo);
    tick();
    check({tag, " done_pulse_end"}, {31'b0, done_out}, 32'd0);
  endtask

  initial begin
    #2 rst = 1'b0;
    #10;
    check("reset busy", {31'b0, busy_out}, 32'd0);
    check("reset done", {31'b0, done_out}, 32'd0);
    check("reset HI", HI_out, 32'd0);
    check("reset LO", LO_out, 32'd0);
    rst = 1'b1;
    tick();

    // Stall behaviour while busy with a pending MFHI/MFLO.
    start_in = 1'b1; op_in = 2'b00; Reg1_in = 32'd7; Reg2_in = 32'd6;
    tick();
    start_in = 1'b0;
    hilo_read_in = 1'b1;
    #1 check("stall on hilo_read", {31'b0, stall_out}, 32'd1);
    hilo_read_in = 1'b0;
    #1 check("no stall idle req", {31'b0, stall_out}, 32'd0);
    repeat (31) tick();
    check("mult7x6 busy32", {31'b0, busy_out}, 32'd1);
    tick();
    check("mult7x6 busy33", {31'b0, busy_out}, 32'd1);
    tick();
    check("mult7x6 done", {31'b0, done_out}, 32'd1);
    check("mult7x6 HI", HI_out, 32'h0000_0000);
    check("mult7x6 LO", LO_out, 32'h0000_002A);
    tick();

    run_op("MULT -1x2",  2'b00, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("MULTU max",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("DIV -7/2",   2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("DIVU 100/7", 2'b11, 32'd100,       32'd7,         32'd2,         32'd14);
    run_op("DIV min/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("MULT -3x-5", 2'b00, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0000_0000, 32'd15);

    // MTHI in IDLE.
    hi_we_in = 1'b1; wdata_in = 32'h0000_1234;
    tick();
    hi_we_in = 1'b0;
    check("MTHI HI", HI_out, 32'h0000_1234);
    check("MTHI LO kept", LO_out, 32'd15);

    // Divide by zero, with an MTLO presented mid-op that must be held off.
    start_in = 1'b1; op_in = 2'b11; Reg1_in = 32'd5; Reg2_in = 32'd0;
    tick();
    start_in = 1'b0;
    repeat (5) tick();
    lo_we_in = 1'b1; wdata_in = 32'hDEAD_BEEF;
    #1 check("MTLO busy stall", {31'b0, stall_out}, 32'd1);
    tick();
    lo_we_in = 1'b0;
    repeat (26) tick();
    check("div0 busy33", {31'b0, busy_out}, 32'd1);
    tick();
    check("div0 done", {31'b0, done_out}, 32'd1);
    check("div0 HI", HI_out, 32'h0000_1234);
    check("div0 LO", LO_out, 32'd15);
    tick();

    // Flush mid-run.
    start_in = 1'b1; op_in = 2'b11; Reg1_in = 32'd100; Reg2_in = 32'd7;
    tick();
    start_in = 1'b0;
    repeat (9) tick();
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    check("flush busy", {31'b0, busy_out}, 32'd0);
    check("flush done", {31'b0, done_out}, 32'd0);
    repeat (30) tick();
    check("flush no late done", {31'b0, done_out}, 32'd0);
    check("flush HI", HI_out, 32'h0000_1234);
    check("flush LO", LO_out, 32'd15);

    // Flush in IDLE suppresses a same-cycle start.
    start_in = 1'b1; flush_in = 1'b1; op_in = 2'b00; Reg1_in = 32'd2; Reg2_in = 32'd2;
    tick();
    start_in = 1'b0; flush_in = 1'b0;
    check("idle flush no start", {31'b0, busy_out}, 32'd0);

    // Reset in the middle of a MULT.
    start_in = 1'b1; op_in = 2'b00; Reg1_in = 32'd1000; Reg2_in = 32'd1000;
    tick();
    start_in = 1'b0;
    repeat (19) tick();
    rst = 1'b0;
    #1;
    check("midrst busy", {31'b0, busy_out}, 32'd0);
    check("midrst HI", HI_out, 32'd0);
    check("midrst LO", LO_out, 32'd0);
    #2 rst = 1'b1;
    tick();
    run_op("MULT 3x3", 2'b00, 32'd3, 32'd3, 32'd0, 32'd9);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
